// File: rtl/spu_pkg.sv
// Shared SPU parameters and small helpers used by the result-retire block.
package spu_pkg;

  localparam int unsigned SPU_REG_W  = 128;
  localparam int unsigned SPU_ADDR_W = 7;
  localparam int unsigned SPU_DEPTH  = 7;
  localparam int unsigned LAT_W      = 3;

  // Source of the winning forwarding match.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_EVEN = 2'd1,
    SRC_ODD  = 2'd2
  } fwd_src_e;

  // A latency of zero is treated as one.
  function automatic logic [LAT_W-1:0] eff_lat(input logic [LAT_W-1:0] lat);
    return (lat == '0) ? LAT_W'(1) : lat;
  endfunction

endpackage

// File: rtl/retire_pipe.sv
// One in-order retire pipe: DEPTH shift stages with per-stage ready and match flags.
module retire_pipe
  import spu_pkg::*;
#(
  parameter int unsigned REG_W  = SPU_REG_W,
  parameter int unsigned ADDR_W = SPU_ADDR_W,
  parameter int unsigned DEPTH  = SPU_DEPTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  input  logic [ADDR_W-1:0]               in_addr,
  input  logic [REG_W-1:0]                in_data,
  input  logic [LAT_W-1:0]                in_lat,
  input  logic                            flush,
  input  logic [ADDR_W-1:0]               fwd_addr,
  output logic                            out_valid,
  output logic [ADDR_W-1:0]               out_addr,
  output logic [REG_W-1:0]                out_data,
  output logic [DEPTH-1:0]                match_vec,
  output logic [DEPTH-1:0]                ready_vec,
  output logic [DEPTH-1:0][REG_W-1:0]     stage_data
);

  // Index 0 is stage s1 (youngest), index DEPTH-1 is the retiring stage.
  logic [DEPTH-1:0]              valid_q, valid_d;
  logic [DEPTH-1:0][ADDR_W-1:0]  addr_q,  addr_d;
  logic [DEPTH-1:0][REG_W-1:0]   data_q,  data_d;
  logic [DEPTH-1:0][LAT_W-1:0]   lat_q,   lat_d;

  // Next-state: load s1 from the issue port, shift the rest; flush kills every valid.
  always_comb begin
    valid_d = '0;
    addr_d  = '0;
    data_d  = '0;
    lat_d   = '0;
    valid_d[0] = in_valid && !flush;
    addr_d[0]  = in_addr;
    data_d[0]  = in_data;
    lat_d[0]   = in_lat;
    for (int i = 1; i < int'(DEPTH); i++) begin
      valid_d[i] = valid_q[i-1] && !flush;
      addr_d[i]  = addr_q[i-1];
      data_d[i]  = data_q[i-1];
      lat_d[i]   = lat_q[i-1];
    end
  end

  // Stage registers, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      lat_q   <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      lat_q   <= lat_d;
    end
  end

  // Per-stage ready (stage number >= effective latency) and address match flags.
  always_comb begin
    ready_vec = '0;
    match_vec = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      ready_vec[i] = (32'(i) + 32'd1) >= 32'(eff_lat(lat_q[i]));
      match_vec[i] = valid_q[i] && (addr_q[i] == fwd_addr);
    end
  end

  assign stage_data = data_q;
  assign out_valid  = valid_q[DEPTH-1];
  assign out_addr   = addr_q[DEPTH-1];
  assign out_data   = data_q[DEPTH-1];

endmodule

// File: rtl/result_retire.sv
// Dual-pipe result retire: two retire pipes feeding register-file write ports,
// plus a combinational youngest-match forwarding network across both pipes.
module result_retire
  import spu_pkg::*;
#(
  parameter int unsigned REG_W  = SPU_REG_W,
  parameter int unsigned ADDR_W = SPU_ADDR_W,
  parameter int unsigned DEPTH  = SPU_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ev_valid,
  input  logic [ADDR_W-1:0] ev_addr,
  input  logic [REG_W-1:0]  ev_data,
  input  logic [2:0]        ev_lat,
  input  logic              od_valid,
  input  logic [ADDR_W-1:0] od_addr,
  input  logic [REG_W-1:0]  od_data,
  input  logic [2:0]        od_lat,
  input  logic              flush,
  output logic              reg_write_en_1,
  output logic [ADDR_W-1:0] reg_write_addr_1,
  output logic [REG_W-1:0]  reg_write_data_1,
  output logic              reg_write_en_2,
  output logic [ADDR_W-1:0] reg_write_addr_2,
  output logic [REG_W-1:0]  reg_write_data_2,
  input  logic [ADDR_W-1:0] fwd_addr,
  output logic              fwd_hit,
  output logic [REG_W-1:0]  fwd_data,
  output logic              fwd_stall
);

  logic [DEPTH-1:0]            ev_match, ev_ready;
  logic [DEPTH-1:0]            od_match, od_ready;
  logic [DEPTH-1:0][REG_W-1:0] ev_stage_data, od_stage_data;

  fwd_src_e                    win_src;
  logic                        win_ready;
  logic [REG_W-1:0]            win_data;

  // Even pipe drives write port 1.
  retire_pipe #(
    .REG_W  (REG_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_even (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (ev_valid),
    .in_addr    (ev_addr),
    .in_data    (ev_data),
    .in_lat     (ev_lat),
    .flush      (flush),
    .fwd_addr   (fwd_addr),
    .out_valid  (reg_write_en_1),
    .out_addr   (reg_write_addr_1),
    .out_data   (reg_write_data_1),
    .match_vec  (ev_match),
    .ready_vec  (ev_ready),
    .stage_data (ev_stage_data)
  );

  // Odd pipe drives write port 2.
  retire_pipe #(
    .REG_W  (REG_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_odd (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (od_valid),
    .in_addr    (od_addr),
    .in_data    (od_data),
    .in_lat     (od_lat),
    .flush      (flush),
    .fwd_addr   (fwd_addr),
    .out_valid  (reg_write_en_2),
    .out_addr   (reg_write_addr_2),
    .out_data   (reg_write_data_2),
    .match_vec  (od_match),
    .ready_vec  (od_ready),
    .stage_data (od_stage_data)
  );

  // Forwarding priority: walk oldest to youngest so the lowest stage overwrites;
  // within a stage the even pipe is applied last so it wins ties.
  always_comb begin
    win_src   = SRC_NONE;
    win_ready = 1'b0;
    win_data  = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (od_match[i]) begin
        win_src   = SRC_ODD;
        win_ready = od_ready[i];
        win_data  = od_stage_data[i];
      end
      if (ev_match[i]) begin
        win_src   = SRC_EVEN;
        win_ready = ev_ready[i];
        win_data  = ev_stage_data[i];
      end
    end
    fwd_hit   = (win_src != SRC_NONE) && win_ready;
    fwd_stall = (win_src != SRC_NONE) && !win_ready;
    fwd_data  = fwd_hit ? win_data : '0;
  end

endmodule

// File: tb/tb_result_retire.sv
// Directed self-checking bench for result_retire.
module tb_result_retire;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         ev_valid, od_valid, flush;
  logic [6:0]   ev_addr, od_addr, fwd_addr;
  logic [127:0] ev_data, od_data;
  logic [2:0]   ev_lat, od_lat;
  logic         reg_write_en_1, reg_write_en_2;
  logic [6:0]   reg_write_addr_1, reg_write_addr_2;
  logic [127:0] reg_write_data_1, reg_write_data_2;
  logic         fwd_hit, fwd_stall;
  logic [127:0] fwd_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  result_retire dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ev_valid         (ev_valid),
    .ev_addr          (ev_addr),
    .ev_data          (ev_data),
    .ev_lat           (ev_lat),
    .od_valid         (od_valid),
    .od_addr          (od_addr),
    .od_data          (od_data),
    .od_lat           (od_lat),
    .flush            (flush),
    .reg_write_en_1   (reg_write_en_1),
    .reg_write_addr_1 (reg_write_addr_1),
    .reg_write_data_1 (reg_write_data_1),
    .reg_write_en_2   (reg_write_en_2),
    .reg_write_addr_2 (reg_write_addr_2),
    .reg_write_data_2 (reg_write_data_2),
    .fwd_addr         (fwd_addr),
    .fwd_hit          (fwd_hit),
    .fwd_data         (fwd_data),
    .fwd_stall        (fwd_stall)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    ev_valid = 1'b0;
    od_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic set_ev(input logic [6:0] a, input logic [127:0] d, input logic [2:0] l);
    ev_valid = 1'b1; ev_addr = a; ev_data = d; ev_lat = l;
  endtask

  task automatic set_od(input logic [6:0] a, input logic [127:0] d, input logic [2:0] l);
    od_valid = 1'b1; od_addr = a; od_data = d; od_lat = l;
  endtask

  task automatic drain();
    idle();
    repeat (8) step();
  endtask

  task automatic test_reset();
    #3;
    checks++; if (reg_write_en_1 !== 1'b0) begin failures++; $display("FAIL reset_en1 got=%0h exp=0", reg_write_en_1); end
    checks++; if (reg_write_en_2 !== 1'b0) begin failures++; $display("FAIL reset_en2 got=%0h exp=0", reg_write_en_2); end
    checks++; if (reg_write_addr_1 !== 7'd0) begin failures++; $display("FAIL reset_addr1 got=%0h exp=0", reg_write_addr_1); end
    checks++; if (fwd_hit !== 1'b0 || fwd_stall !== 1'b0) begin failures++; $display("FAIL reset_fwd hit=%0h stall=%0h exp=0/0", fwd_hit, fwd_stall); end
    checks++; if (fwd_data !== 128'd0) begin failures++; $display("FAIL reset_fwd_data got=%0h exp=0", fwd_data); end
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_write_latency();
    logic [127:0] d;
    d = {16{8'hAA}};
    fwd_addr = 7'd100;
    set_ev(7'd5, d, 3'd1);
    for (int k = 0; k < 8; k++) begin
      step();
      idle();
      #1;
      checks++; if (reg_write_en_1 !== 1'(k == 6)) begin failures++; $display("FAIL wlat_en1 edge=%0d got=%0h exp=%0h", k, reg_write_en_1, (k == 6)); end
      checks++; if (reg_write_en_2 !== 1'b0) begin failures++; $display("FAIL wlat_en2 edge=%0d got=%0h exp=0", k, reg_write_en_2); end
      if (k == 6) begin
        checks++; if (reg_write_addr_1 !== 7'd5) begin failures++; $display("FAIL wlat_addr1 got=%0h exp=5", reg_write_addr_1); end
        checks++; if (reg_write_data_1 !== d) begin failures++; $display("FAIL wlat_data1 got=%0h exp=%0h", reg_write_data_1, d); end
      end
    end
    drain();
  endtask

  task automatic test_fwd_latency();
    logic [127:0] d;
    d = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    fwd_addr = 7'd9;
    set_od(7'd9, d, 3'd3);
    for (int k = 0; k < 8; k++) begin
      step();
      idle();
      #1;
      checks++; if (fwd_stall !== 1'(k < 2)) begin failures++; $display("FAIL flat_stall edge=%0d got=%0h exp=%0h", k, fwd_stall, (k < 2)); end
      checks++; if (fwd_hit !== 1'(k >= 2 && k <= 6)) begin failures++; $display("FAIL flat_hit edge=%0d got=%0h exp=%0h", k, fwd_hit, (k >= 2 && k <= 6)); end
      checks++; if (fwd_data !== ((k >= 2 && k <= 6) ? d : 128'd0)) begin failures++; $display("FAIL flat_data edge=%0d got=%0h", k, fwd_data); end
      if (k == 6) begin
        checks++; if (reg_write_en_2 !== 1'b1 || reg_write_addr_2 !== 7'd9) begin failures++; $display("FAIL flat_wr2 en=%0h addr=%0h exp=1/9", reg_write_en_2, reg_write_addr_2); end
      end
    end
    drain();
  endtask

  task automatic test_youngest();
    fwd_addr = 7'd4;
    set_ev(7'd4, 128'd1, 3'd1);
    step();
    set_ev(7'd4, 128'd2, 3'd1);
    #1;
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 128'd1) begin failures++; $display("FAIL young_e0 hit=%0h data=%0h exp=1/1", fwd_hit, fwd_data); end
    step();
    set_ev(7'd4, 128'd3, 3'd7);
    #1;
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 128'd2) begin failures++; $display("FAIL young_e1 hit=%0h data=%0h exp=1/2", fwd_hit, fwd_data); end
    step();
    idle();
    #1;
    checks++; if (fwd_stall !== 1'b1 || fwd_hit !== 1'b0 || fwd_data !== 128'd0) begin failures++; $display("FAIL young_notready stall=%0h hit=%0h data=%0h exp=1/0/0", fwd_stall, fwd_hit, fwd_data); end
    drain();
    set_ev(7'd4, 128'h44, 3'd0);
    step();
    idle();
    #1;
    checks++; if (fwd_hit !== 1'b1 || fwd_stall !== 1'b0 || fwd_data !== 128'h44) begin failures++; $display("FAIL lat0 hit=%0h stall=%0h data=%0h exp=1/0/44", fwd_hit, fwd_stall, fwd_data); end
    drain();
  endtask

  task automatic test_dual();
    fwd_addr = 7'd7;
    set_ev(7'd7, 128'h11, 3'd1);
    set_od(7'd7, 128'h22, 3'd1);
    step();
    idle();
    set_od(7'd7, 128'h33, 3'd1);
    #1;
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 128'h11) begin failures++; $display("FAIL dual_tie hit=%0h data=%0h exp=1/11", fwd_hit, fwd_data); end
    step();
    idle();
    #1;
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 128'h33) begin failures++; $display("FAIL dual_oddyoung hit=%0h data=%0h exp=1/33", fwd_hit, fwd_data); end
    for (int k = 2; k < 9; k++) begin
      step();
      #1;
      checks++; if (reg_write_en_1 !== 1'(k == 6)) begin failures++; $display("FAIL dual_en1 edge=%0d got=%0h exp=%0h", k, reg_write_en_1, (k == 6)); end
      checks++; if (reg_write_en_2 !== 1'(k == 6 || k == 7)) begin failures++; $display("FAIL dual_en2 edge=%0d got=%0h exp=%0h", k, reg_write_en_2, (k == 6 || k == 7)); end
      if (k == 6) begin
        checks++; if (reg_write_addr_1 !== 7'd7 || reg_write_addr_2 !== 7'd7) begin failures++; $display("FAIL dual_addr a1=%0h a2=%0h exp=7/7", reg_write_addr_1, reg_write_addr_2); end
        checks++; if (reg_write_data_1 !== 128'h11 || reg_write_data_2 !== 128'h22) begin failures++; $display("FAIL dual_data d1=%0h d2=%0h exp=11/22", reg_write_data_1, reg_write_data_2); end
      end
      if (k == 7) begin
        checks++; if (reg_write_data_2 !== 128'h33) begin failures++; $display("FAIL dual_data2b got=%0h exp=33", reg_write_data_2); end
      end
    end
    drain();
  endtask

  task automatic test_flush();
    fwd_addr = 7'd1;
    set_ev(7'd1, 128'h1, 3'd1);
    step();
    idle();
    set_od(7'd2, 128'h2, 3'd1);
    step();
    idle();
    set_ev(7'd3, 128'h3, 3'd1);
    step();
    idle();
    #1;
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 128'h1) begin failures++; $display("FAIL flush_pre hit=%0h data=%0h exp=1/1", fwd_hit, fwd_data); end
    flush = 1'b1;
    set_ev(7'd1, 128'hF, 3'd1);
    step();
    idle();
    set_ev(7'd6, 128'h66, 3'd1);
    #1;
    checks++; if (fwd_hit !== 1'b0 || fwd_stall !== 1'b0) begin failures++; $display("FAIL flush_fwd hit=%0h stall=%0h exp=0/0", fwd_hit, fwd_stall); end
    for (int k = 4; k < 12; k++) begin
      step();
      idle();
      #1;
      checks++; if (reg_write_en_1 !== 1'(k == 10)) begin failures++; $display("FAIL flush_en1 edge=%0d got=%0h exp=%0h", k, reg_write_en_1, (k == 10)); end
      checks++; if (reg_write_en_2 !== 1'b0 || fwd_hit !== 1'b0) begin failures++; $display("FAIL flush_en2hit edge=%0d en2=%0h hit=%0h exp=0/0", k, reg_write_en_2, fwd_hit); end
      if (k == 10) begin
        checks++; if (reg_write_addr_1 !== 7'd6 || reg_write_data_1 !== 128'h66) begin failures++; $display("FAIL flush_new addr=%0h data=%0h exp=6/66", reg_write_addr_1, reg_write_data_1); end
      end
    end
    drain();
  endtask

  task automatic test_flush_s7();
    fwd_addr = 7'd100;
    set_ev(7'd8, 128'h88, 3'd1);
    step();
    idle();
    set_ev(7'd12, 128'hCC, 3'd1);
    step();
    idle();
    repeat (5) step();
    #1;
    checks++; if (reg_write_en_1 !== 1'b1 || reg_write_addr_1 !== 7'd8) begin failures++; $display("FAIL fs7_pre en=%0h addr=%0h exp=1/8", reg_write_en_1, reg_write_addr_1); end
    flush = 1'b1;
    #1;
    checks++; if (reg_write_en_1 !== 1'b1 || reg_write_data_1 !== 128'h88) begin failures++; $display("FAIL fs7_during en=%0h data=%0h exp=1/88", reg_write_en_1, reg_write_data_1); end
    for (int k = 0; k < 3; k++) begin
      step();
      idle();
      #1;
      checks++; if (reg_write_en_1 !== 1'b0) begin failures++; $display("FAIL fs7_after cycle=%0d got=%0h exp=0", k, reg_write_en_1); end
    end
    drain();
  endtask

  task automatic test_reset_mid();
    fwd_addr = 7'd20;
    set_ev(7'd20, 128'h20, 3'd1);
    step();
    idle();
    set_od(7'd21, 128'h21, 3'd1);
    step();
    idle();
    #1;
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 128'h20) begin failures++; $display("FAIL rmid_pre hit=%0h data=%0h exp=1/20", fwd_hit, fwd_data); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (fwd_hit !== 1'b0 || fwd_stall !== 1'b0 || fwd_data !== 128'd0) begin failures++; $display("FAIL rmid_fwd hit=%0h stall=%0h data=%0h exp=0", fwd_hit, fwd_stall, fwd_data); end
    checks++; if (reg_write_en_1 !== 1'b0 || reg_write_en_2 !== 1'b0 || reg_write_addr_2 !== 7'd0 || reg_write_data_1 !== 128'd0) begin failures++; $display("FAIL rmid_wr en1=%0h en2=%0h exp=0/0", reg_write_en_1, reg_write_en_2); end
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    fwd_addr = 7'd22;
    set_ev(7'd22, 128'h55, 3'd1);
    for (int k = 0; k < 8; k++) begin
      step();
      idle();
      #1;
      checks++; if (reg_write_en_1 !== 1'(k == 6) || reg_write_en_2 !== 1'b0) begin failures++; $display("FAIL rmid_post edge=%0d en1=%0h en2=%0h exp=%0h/0", k, reg_write_en_1, reg_write_en_2, (k == 6)); end
      if (k == 0) begin
        checks++; if (fwd_hit !== 1'b1 || fwd_data !== 128'h55) begin failures++; $display("FAIL rmid_accept hit=%0h data=%0h exp=1/55", fwd_hit, fwd_data); end
      end
      if (k == 6) begin
        checks++; if (reg_write_addr_1 !== 7'd22) begin failures++; $display("FAIL rmid_addr got=%0h exp=22", reg_write_addr_1); end
      end
    end
    drain();
  endtask

  initial begin
    ev_valid = 1'b0; ev_addr = '0; ev_data = '0; ev_lat = '0;
    od_valid = 1'b0; od_addr = '0; od_data = '0; od_lat = '0;
    flush = 1'b0;
    fwd_addr = '0;
    #1;
    rst_n = 1'b0;
    test_reset();
    test_write_latency();
    test_fwd_latency();
    test_youngest();
    test_dual();
    test_flush();
    test_flush_s7();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/result_retire.md
RESULT_RETIRE -- requirements
Module: result_retire

Interface
REQ-001 SHALL have parameter REG_W, default 128, register data width.
REQ-002 SHALL have parameter ADDR_W, default 7, register address width (128 registers).
REQ-003 SHALL have parameter DEPTH, default 7, number of retire stages per pipe.
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock.
REQ-005 SHALL have rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ev_valid  in  1  even-pipe result issue strobe.
REQ-007 SHALL have ev_addr  in  ADDR_W  even-pipe target register.
REQ-008 SHALL have ev_data  in  REG_W  even-pipe result.
REQ-009 SHALL have ev_lat  in  3  even-pipe ready latency, 1..7.
REQ-010 SHALL have od_valid, od_addr, od_data, od_lat  in  1/ADDR_W/REG_W/3  odd-pipe equivalents.
REQ-011 SHALL have flush  in  1  discard all in-flight results.
REQ-012 SHALL have reg_write_en_1, reg_write_addr_1, reg_write_data_1  out  1/ADDR_W/REG_W  even-pipe register-file write port.
REQ-013 SHALL have reg_write_en_2, reg_write_addr_2, reg_write_data_2  out  1/ADDR_W/REG_W  odd-pipe register-file write port.
REQ-014 SHALL have fwd_addr  in  ADDR_W  forwarding query address.
REQ-015 SHALL have fwd_hit  out  1  ready in-flight result matches fwd_addr.
REQ-016 SHALL have fwd_data  out  REG_W  forwarded value, valid when fwd_hit.
REQ-017 SHALL have fwd_stall  out  1  youngest match to fwd_addr is not yet ready.

Function
REQ-018 SHALL keep per pipe a DEPTH-stage in-order shift register s1..s7 of {valid, addr, data, lat}; all stages advance every cycle, with no back-pressure.
REQ-019 SHALL load s1 from the pipe inputs at each edge, with valid = *_valid && !flush.
REQ-020 SHALL drive write port 1 combinationally from even s7 and port 2 from odd s7; en = s7.valid. An issue at edge E0 writes in the cycle after edge E6.
REQ-021 SHALL treat an entry in stage sN as ready when N >= lat; lat=0 SHALL be treated as 1.
REQ-022 SHALL search all valid stages of both pipes for addr == fwd_addr; the youngest match (lowest N) wins; on an equal-stage tie the even pipe wins.
REQ-023 SHALL, if the winning match is ready: fwd_hit=1, fwd_stall=0, fwd_data=its data; if not ready: fwd_hit=0, fwd_stall=1; with no match: both 0 and fwd_data=0.
REQ-024 SHALL assert both write enables when both s7 entries target the same address; the register file resolves this with port 1 priority, and this block performs no filtering.
REQ-025 SHALL, on flush at an edge, clear valid in every stage. The s7 entries presented during the flush cycle still write.
REQ-026 SHALL compute the forwarding outputs combinationally, in the same cycle as fwd_addr.

Reset
REQ-027 SHALL, while rst_n=0, clear all stage valid/addr/data/lat to 0 asynchronously, giving all outputs 0.
REQ-028 SHALL discard in-flight results on reset mid-operation, with no write after release; issue SHALL be accepted at the first edge after release.

Structure
REQ-029 SHALL take REG_W, ADDR_W and DEPTH defaults from shared package spu_pkg.
REQ-030 SHALL implement one pipe as sub-module retire_pipe (stages, ready flags, per-stage match vector), instantiated twice, with the cross-pipe forwarding priority mux in the top level.

Verification
REQ-031 SHALL cover: ev_valid, addr 5, data 0xAA..AA at E0 -> reg_write_en_1=1, addr 5, data 0xAA..AA only in the cycle after E6.
REQ-032 SHALL cover: od issue addr 9, lat 3 at E0; fwd_addr=9 -> fwd_stall=1 after E0 and E1; fwd_hit=1, fwd_data=od data after E2 through E6.
REQ-033 SHALL cover: even addr 4 data 1 at E0, even addr 4 data 2 at E1, both lat 1 -> after E1 fwd_data=2 (youngest wins).
REQ-034 SHALL cover: both pipes addr 7, same edge, lat 1 -> fwd_data=even data; 6 cycles later both write enables assert with addr 7.
REQ-035 SHALL cover: three issues in flight, flush at edge E3 -> no further write enables and fwd_hit=0; a new issue at E4 writes after E10.
REQ-036 SHALL cover: rst_n low mid-flight -> all outputs 0 immediately; after release, no stale writes appear.
